reg_file_2r1w: RTL

REG_FILE_2R1W -- requirements
Module: reg_file_2r1w

---
 rtl/reg_file_2r1w.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/reg_file_2r1w.sv
// ----------------------------------------------------------------------------
// reg_file_2r1w
//
// Register file with two read ports and one write port, held entirely in
// flip-flops, so that the asynchronous reset can zero every entry at once.
// A single-cycle clear request starts a sweep that zeroes one register per
// clock. External writes are blocked while the sweep runs.
//
// Parameters
//   DATA_WIDTH  bits per register
//   ADDR_WIDTH  address bits, DEPTH = 2**ADDR_WIDTH registers
//   ZERO_REG    1: register 0 is hardwired to zero (writes dropped, reads 0)
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   we           write enable (ignored while busy)
//   w_address    write address
//   w_data       write data
//   re_a         read enable, port A
//   r_address_a  read address, port A
//   r_data_a     registered read data, port A (holds while re_a=0)
//   re_b         read enable, port B
//   r_address_b  read address, port B
//   r_data_b     registered read data, port B (holds while re_b=0)
//   clear        single-cycle request to zero all registers
//   busy         high while the clear sweep is in progress
// ----------------------------------------------------------------------------
module reg_file_2r1w #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] w_address,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  re_a,
    input  logic [ADDR_WIDTH-1:0] r_address_a,
    output logic [DATA_WIDTH-1:0] r_data_a,
    input  logic                  re_b,
    input  logic [ADDR_WIDTH-1:0] r_address_b,
    output logic [DATA_WIDTH-1:0] r_data_b,
    input  logic                  clear,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam bit HAS_ZERO_REG = (ZERO_REG != 0);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   count_reg;
    logic [ADDR_WIDTH-1:0]   count_next;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_reg;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_next;

    // Index 0 is port A, index 1 is port B.
    logic [1:0]                       rd_en;
    logic [1:0][ADDR_WIDTH-1:0]       rd_addr;
    logic [1:0][DATA_WIDTH-1:0]       rd_reg;
    logic [1:0][DATA_WIDTH-1:0]       rd_next;

    logic sweep_active;
    logic write_accept;

    assign sweep_active = (state_reg == CLEAR);

    // A write lands only when no sweep is running, and never on the
    // hardwired zero register.
    assign write_accept = we && !sweep_active &&
                          !(HAS_ZERO_REG && (w_address == '0));

    // ------------------------------------------------------------------
    // Sweep FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        case (state_reg)
            IDLE: begin
                if (clear) begin
                    state_next = CLEAR;
                    count_next = '0;
                end
            end
            CLEAR: begin
                // clear is deliberately not looked at here: a request
                // during a sweep neither restarts nor extends it.
                count_next = count_reg + 1'b1;
                if (count_reg == LAST_ADDR) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-register next value: sweep zeroing has priority, but the two
    // never collide because external writes are blocked during a sweep.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
            localparam logic [ADDR_WIDTH-1:0] IDX = ADDR_WIDTH'(gi);
            if (HAS_ZERO_REG && (gi == 0)) begin : g_hard_zero
                assign mem_next[gi] = '0;
            end else begin : g_normal
                assign mem_next[gi] =
                    (sweep_active && (count_reg == IDX)) ? '0 :
                    (write_accept && (w_address == IDX)) ? w_data :
                    mem_reg[gi];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read ports. Write-first bypass only for accepted external writes;
    // sweep writes are not bypassed, so a read during the sweep returns
    // the content from before that edge.
    // ------------------------------------------------------------------
    assign rd_en   = {re_b, re_a};
    assign rd_addr = {r_address_b, r_address_a};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic zero_hit;
            logic bypass_hit;

            assign zero_hit   = HAS_ZERO_REG && (rd_addr[gi] == '0);
            assign bypass_hit = write_accept && (rd_addr[gi] == w_address);

            assign rd_next[gi] =
                !rd_en[gi] ? rd_reg[gi] :
                zero_hit   ? '0 :
                bypass_hit ? w_data :
                mem_reg[rd_addr[gi]];
        end
    endgenerate

    // ------------------------------------------------------------------
    // State, storage and read registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            mem_reg   <= '0;
            rd_reg    <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            mem_reg   <= mem_next;
            rd_reg    <= rd_next;
        end
    end

    assign r_data_a = rd_reg[0];
    assign r_data_b = rd_reg[1];
    assign busy     = sweep_active;

endmodule
